// File: rtl/score_digit_encoder.sv
// Pong score keeper: counts point pulses for two players, detects game end and
// drives registered 7-segment masks for the two on-screen digit renderers.
module score_digit_encoder #(
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_point_p1,
    input  logic       i_point_p2,
    input  logic       i_restart,
    input  logic       i_frame_start,
    output logic [6:0] o_digit_p1,
    output logic [6:0] o_digit_p2,
    output logic       o_game_over,
    output logic [1:0] o_winner
);

    localparam int unsigned CntW = $clog2(BLINK_FRAMES + 1);
    localparam logic [3:0] WinVal = 4'(WIN_SCORE);
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_FRAMES - 1);
    localparam logic [6:0] SegZero = 7'h77;

    typedef enum logic [0:0] {
        StPlay,
        StWin
    } state_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'd0:    seg = 7'h77;
            4'd1:    seg = 7'h24;
            4'd2:    seg = 7'h5D;
            4'd3:    seg = 7'h6D;
            4'd4:    seg = 7'h2E;
            4'd5:    seg = 7'h6B;
            4'd6:    seg = 7'h7B;
            4'd7:    seg = 7'h25;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      score1_q, score1_d;
    logic [3:0]      score2_q, score2_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            blink_on_q, blink_on_d;
    logic [6:0]      digit_p1_q, digit_p1_d;
    logic [6:0]      digit_p2_q, digit_p2_d;
    logic            game_over_q, game_over_d;
    logic [1:0]      winner_q, winner_d;
    logic            hit1, hit2;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= StPlay;
        end else begin
            state_q <= state_d;
        end
    end

    // Scores only move while playing and saturate at the winning value
    always_comb begin
        score1_d = score1_q;
        score2_d = score2_q;
        if (i_restart) begin
            score1_d = 4'd0;
            score2_d = 4'd0;
        end else if (state_q == StPlay) begin
            if (i_point_p1 && (score1_q < WinVal)) begin
                score1_d = score1_q + 4'd1;
            end
            if (i_point_p2 && (score2_q < WinVal)) begin
                score2_d = score2_q + 4'd1;
            end
        end
    end

    assign hit1 = (score1_d == WinVal);
    assign hit2 = (score2_d == WinVal);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (i_restart) begin
            state_d = StPlay;
        end else begin
            case (state_q)
                StPlay:  if (hit1 || hit2) state_d = StWin;
                StWin:   state_d = StWin;
                default: state_d = StPlay;
            endcase
        end
    end

    // Blink timer runs only in the win state; playing holds it cleared and lit
    always_comb begin
        cnt_d      = cnt_q;
        blink_on_d = blink_on_q;
        if (i_restart || (state_q != StWin)) begin
            cnt_d      = '0;
            blink_on_d = 1'b1;
        end else if (i_frame_start) begin
            if (cnt_q == CntLast) begin
                cnt_d      = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Output logic, computed from next-state values so the registers line up
    always_comb begin
        winner_d = winner_q;
        if (i_restart) begin
            winner_d = 2'b00;
        end else if ((state_q == StPlay) && (state_d == StWin)) begin
            winner_d = {hit2, hit1};
        end
        game_over_d = (state_d == StWin);
        digit_p1_d  = seg_encode(score1_d);
        digit_p2_d  = seg_encode(score2_d);
        if (game_over_d && !blink_on_d) begin
            if (winner_d[0]) digit_p1_d = 7'h00;
            if (winner_d[1]) digit_p2_d = 7'h00;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            cnt_q       <= '0;
            blink_on_q  <= 1'b1;
            digit_p1_q  <= SegZero;
            digit_p2_q  <= SegZero;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
        end else begin
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            cnt_q       <= cnt_d;
            blink_on_q  <= blink_on_d;
            digit_p1_q  <= digit_p1_d;
            digit_p2_q  <= digit_p2_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign o_digit_p1  = digit_p1_q;
    assign o_digit_p2  = digit_p2_q;
    assign o_game_over = game_over_q;
    assign o_winner    = winner_q;

endmodule

// File: tb/tb_score_digit_encoder.sv
// Directed bench for score_digit_encoder with a behavioural scoreboard model.
module tb_score_digit_encoder;

    localparam int unsigned WinScore = 9;
    localparam int unsigned Blink    = 2;

    typedef struct packed {
        logic [6:0] d1;
        logic [6:0] d2;
        logic       go;
        logic [1:0] w;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, p1, p2, rs, fs;
    logic [6:0] d1, d2;
    logic       go;
    logic [1:0] w;

    always #5 clk = ~clk;

    score_digit_encoder #(
        .WIN_SCORE    (WinScore),
        .BLINK_FRAMES (Blink)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_point_p1    (p1),
        .i_point_p2    (p2),
        .i_restart     (rs),
        .i_frame_start (fs),
        .o_digit_p1    (d1),
        .o_digit_p2    (d2),
        .o_game_over   (go),
        .o_winner      (w)
    );

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         m_s1, m_s2, m_cnt;
    bit         m_win, m_blink;
    logic [1:0] m_w;
    logic [6:0] seg_tab[10] = '{7'h77, 7'h24, 7'h5D, 7'h6D, 7'h2E,
                                7'h6B, 7'h7B, 7'h25, 7'h7F, 7'h6F};

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_s1    = 0;
        m_s2    = 0;
        m_cnt   = 0;
        m_win   = 1'b0;
        m_blink = 1'b1;
        m_w     = 2'b00;
    endtask

    task automatic step(input logic a_p1, input logic a_p2, input logic a_rs,
                        input logic a_fs, input logic a_rst, input string tag);
        exp_t e;
        exp_t got;
        p1  = a_p1;
        p2  = a_p2;
        rs  = a_rs;
        fs  = a_fs;
        rst = a_rst;
        if (a_rst || a_rs) begin
            model_clear();
        end else if (!m_win) begin
            if (a_p1 && m_s1 < WinScore) m_s1++;
            if (a_p2 && m_s2 < WinScore) m_s2++;
            if (m_s1 == WinScore || m_s2 == WinScore) begin
                m_win = 1'b1;
                m_w   = {m_s2 == WinScore, m_s1 == WinScore};
            end
        end else if (a_fs) begin
            m_cnt++;
            if (m_cnt == Blink) begin
                m_cnt   = 0;
                m_blink = !m_blink;
            end
        end
        e.d1 = (m_win && m_w[0] && !m_blink) ? 7'h00 : seg_tab[m_s1];
        e.d2 = (m_win && m_w[1] && !m_blink) ? 7'h00 : seg_tab[m_s2];
        e.go = m_win;
        e.w  = m_w;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            got = '{d1: d1, d2: d2, go: go, w: w};
            check({tag, ".d1"}, got.d1, e.d1);
            check({tag, ".d2"}, got.d2, e.d2);
            check({tag, ".go"}, 7'(got.go), 7'(e.go));
            check({tag, ".w"}, 7'(got.w), 7'(e.w));
        end
    endtask

    initial begin
        {p1, p2, rs, fs, rst} = '0;
        model_clear();

        step(0, 0, 0, 0, 1, "reset0");
        step(0, 0, 0, 0, 1, "reset1");
        step(0, 0, 0, 0, 0, "idle_after_reset");

        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, "p1_point");
            step(0, 0, 0, 0, 0, "p1_gap");
        end

        // Frames while playing must not advance the blink counter
        step(0, 0, 0, 1, 0, "frame_in_play0");
        step(0, 0, 0, 1, 0, "frame_in_play1");
        step(0, 0, 0, 1, 0, "frame_in_play2");

        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, "p2_to8");
        step(0, 1, 0, 0, 0, "p2_wins");
        step(0, 1, 0, 0, 0, "p2_frozen");
        step(1, 0, 0, 0, 0, "p1_frozen");

        step(0, 0, 0, 1, 0, "blink_f1");
        step(0, 0, 0, 0, 0, "blink_gap");
        step(0, 0, 0, 1, 0, "blink_off");
        step(0, 0, 0, 1, 0, "blink_f3");
        step(0, 0, 0, 1, 0, "blink_on");
        step(0, 0, 0, 1, 0, "blink_f5");

        step(1, 0, 1, 0, 0, "restart_with_point");
        step(0, 0, 0, 0, 0, "after_restart");

        for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0, "both_to8");
        step(1, 1, 0, 0, 0, "tie_win");
        step(0, 0, 0, 1, 0, "tie_f1");
        step(0, 0, 0, 1, 0, "tie_blink_off");

        step(0, 0, 1, 0, 0, "restart2");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, "p1_to5");
        step(1, 0, 0, 0, 1, "reset_with_point");
        step(0, 0, 0, 0, 0, "after_reset");

        // Reset mid-blink
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0, "p1_to9");
        step(0, 0, 0, 1, 0, "p1win_f1");
        step(0, 0, 0, 1, 0, "p1win_off");
        step(0, 0, 0, 0, 1, "reset_mid_blink");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
